// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, fetches one 32-bit word per cycle into a
// small prefetch FIFO and hands instructions to decode over a valid/ready handshake.
module fetch_controller #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        halt_i,
    input  logic        redirect_valid_i,
    input  logic [7:0]  redirect_target_i,
    output logic [7:0]  mem_addr_o,
    input  logic [31:0] mem_instr_i,
    output logic [31:0] instr_o,
    output logic [7:0]  instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [1:0]  state_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [7:0]         pc_r;
    logic [31:0]        fifo_instr_r [DEPTH];
    logic [7:0]         fifo_pc_r    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic               empty_s;
    logic               full_s;
    logic               pop_s;
    logic               push_s;
    logic               flush_s;
    logic               load_reset_s;
    logic               load_redir_s;

    assign empty_s = (count_r == {CNT_W{1'b0}});
    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign pop_s   = !empty_s && instr_ready_i;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; start_i in RUN is deliberately ignored
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (halt_i) begin
                    state_nxt_s = HALTED;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            HALTED: begin
                if (start_i) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = HALTED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM control outputs: PC load selection, FIFO flush and push enable
    always_comb begin
        push_s       = 1'b0;
        flush_s      = 1'b0;
        load_reset_s = 1'b0;
        load_redir_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    load_reset_s = 1'b1;
                    flush_s      = 1'b1;
                end else begin
                    load_reset_s = 1'b0;
                end
            end
            RUN: begin
                // redirect wins over fetch; a simultaneous halt only affects the state
                if (redirect_valid_i) begin
                    load_redir_s = 1'b1;
                    flush_s      = 1'b1;
                end else if (!halt_i && (!full_s || pop_s)) begin
                    push_s = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
            end
            HALTED: begin
                if (start_i) begin
                    load_reset_s = 1'b1;
                    flush_s      = 1'b1;
                end else if (redirect_valid_i) begin
                    load_redir_s = 1'b1;
                    flush_s      = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
            end
            default: begin
                push_s = 1'b0;
            end
        endcase
    end

    // program counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_r <= RESET_PC;
        end else if (load_reset_s) begin
            pc_r <= RESET_PC;
        end else if (load_redir_s) begin
            pc_r <= redirect_target_i;
        end else if (push_s) begin
            pc_r <= pc_r + 8'd4;
        end else begin
            pc_r <= pc_r;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2 or 4
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush_s) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr_r[i] <= 32'h0000_0000;
                fifo_pc_r[i]    <= 8'h00;
            end
        end else if (push_s) begin
            fifo_instr_r[wr_ptr_r] <= mem_instr_i;
            fifo_pc_r[wr_ptr_r]    <= pc_r;
        end else begin
            fifo_instr_r[wr_ptr_r] <= fifo_instr_r[wr_ptr_r];
            fifo_pc_r[wr_ptr_r]    <= fifo_pc_r[wr_ptr_r];
        end
    end

    // head outputs read zero while the FIFO is empty
    always_comb begin
        if (!empty_s) begin
            instr_o    = fifo_instr_r[rd_ptr_r];
            instr_pc_o = fifo_pc_r[rd_ptr_r];
        end else begin
            instr_o    = 32'h0000_0000;
            instr_pc_o = 8'h00;
        end
    end

    assign instr_valid_o = !empty_s;
    assign mem_addr_o    = pc_r;
    assign state_o       = state_r;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller with a byte-addressed memory model.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start, halt, redir, ready;
    logic [7:0]  target;
    logic [7:0]  mem_addr;
    logic [31:0] mem_instr;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        valid;
    logic [1:0]  state;
    logic [7:0]  mem_bytes [256];
    logic [7:0]  a1, a2, a3;
    int          checks = 0;
    int          failures = 0;

    fetch_controller #(.RESET_PC(8'h00), .DEPTH(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .halt_i(halt),
        .redirect_valid_i(redir), .redirect_target_i(target),
        .mem_addr_o(mem_addr), .mem_instr_i(mem_instr),
        .instr_o(instr), .instr_pc_o(instr_pc), .instr_valid_o(valid),
        .instr_ready_i(ready), .state_o(state)
    );

    always #5 clk = ~clk;

    assign a1 = mem_addr + 8'd1;
    assign a2 = mem_addr + 8'd2;
    assign a3 = mem_addr + 8'd3;
    assign mem_instr = {mem_bytes[a3], mem_bytes[a2], mem_bytes[a1], mem_bytes[mem_addr]};

    function automatic logic [7:0] byte_of(input logic [7:0] x);
        return x * 8'd7 + 8'd3;
    endfunction

    function automatic logic [31:0] exp_word(input logic [7:0] p);
        return {byte_of(p + 8'd3), byte_of(p + 8'd2), byte_of(p + 8'd1), byte_of(p)};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; halt = 1'b0; redir = 1'b0; target = 8'h00; ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #7;
        checks += 4;
        if (mem_addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", mem_addr); end
        if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        if (instr !== 32'h0 || instr_pc !== 8'h00) begin
            failures++; $display("FAIL reset_head got=%h/%h exp=0/0", instr, instr_pc);
        end
        if (state !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", state); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_ignores();
        do_reset();
        redir = 1'b1; target = 8'h50;
        tick();
        redir = 1'b0;
        checks += 2;
        if (mem_addr !== 8'h00) begin failures++; $display("FAIL idle_redir_addr got=%h exp=00", mem_addr); end
        if (state !== 2'b00 || valid !== 1'b0) begin
            failures++; $display("FAIL idle_redir_state got=%b/%b exp=00/0", state, valid);
        end
    endtask

    task automatic test_sequential();
        logic [7:0] p;
        do_reset();
        ready = 1'b1;
        pulse_start();
        checks += 2;
        if (state !== 2'b01) begin failures++; $display("FAIL seq_state got=%b exp=01", state); end
        if (valid !== 1'b0 || mem_addr !== 8'h00) begin
            failures++; $display("FAIL seq_first got=%b/%h exp=0/00", valid, mem_addr);
        end
        p = 8'h00;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks += 2;
            if (valid !== 1'b1 || instr_pc !== p) begin
                failures++; $display("FAIL seq_pc%0d got=%b/%h exp=1/%h", k, valid, instr_pc, p);
            end
            if (instr !== exp_word(p)) begin
                failures++; $display("FAIL seq_word%0d got=%h exp=%h", k, instr, exp_word(p));
            end
            p = p + 8'd4;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] p;
        do_reset();
        pulse_start();
        repeat (5) tick();
        checks += 2;
        if (valid !== 1'b1 || instr_pc !== 8'h00) begin
            failures++; $display("FAIL bp_head got=%b/%h exp=1/00", valid, instr_pc);
        end
        if (mem_addr !== 8'h08) begin failures++; $display("FAIL bp_addr got=%h exp=08", mem_addr); end
        ready = 1'b1;
        p = 8'h04;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (instr_pc !== p || instr !== exp_word(p)) begin
                failures++; $display("FAIL bp_drain%0d got=%h/%h exp=%h/%h", k, instr_pc, instr, p, exp_word(p));
            end
            p = p + 8'd4;
        end
    endtask

    task automatic test_redirect();
        do_reset();
        pulse_start();
        redir = 1'b1; target = 8'h10;
        tick();
        redir = 1'b0;
        repeat (2) tick();
        checks++;
        if (instr_pc !== 8'h10 || mem_addr !== 8'h18) begin
            failures++; $display("FAIL redir_fill got=%h/%h exp=10/18", instr_pc, mem_addr);
        end
        redir = 1'b1; target = 8'h40;
        tick();
        redir = 1'b0;
        checks++;
        if (valid !== 1'b0 || mem_addr !== 8'h40) begin
            failures++; $display("FAIL redir_flush got=%b/%h exp=0/40", valid, mem_addr);
        end
        ready = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b1 || instr_pc !== 8'h40 || instr !== exp_word(8'h40)) begin
            failures++; $display("FAIL redir_first got=%b/%h/%h exp=1/40/%h", valid, instr_pc, instr, exp_word(8'h40));
        end
        tick();
        checks++;
        if (instr_pc !== 8'h44) begin failures++; $display("FAIL redir_second got=%h exp=44", instr_pc); end
    endtask

    task automatic test_wrap();
        logic [7:0] p;
        do_reset();
        ready = 1'b1;
        pulse_start();
        tick();
        redir = 1'b1; target = 8'hF8;
        tick();
        redir = 1'b0;
        p = 8'hF8;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (valid !== 1'b1 || instr_pc !== p || instr !== exp_word(p)) begin
                failures++; $display("FAIL wrap%0d got=%b/%h/%h exp=1/%h/%h", k, valid, instr_pc, instr, p, exp_word(p));
            end
            p = p + 8'd4;
        end
    endtask

    task automatic test_halt();
        do_reset();
        pulse_start();
        repeat (3) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks += 2;
        if (state !== 2'b10) begin failures++; $display("FAIL halt_state got=%b exp=10", state); end
        if (mem_addr !== 8'h08 || valid !== 1'b1 || instr_pc !== 8'h00) begin
            failures++; $display("FAIL halt_hold got=%h/%b/%h exp=08/1/00", mem_addr, valid, instr_pc);
        end
        ready = 1'b1;
        tick();
        checks++;
        if (instr_pc !== 8'h04 || mem_addr !== 8'h08) begin
            failures++; $display("FAIL halt_drain got=%h/%h exp=04/08", instr_pc, mem_addr);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || instr !== 32'h0 || mem_addr !== 8'h08) begin
            failures++; $display("FAIL halt_empty got=%b/%h/%h exp=0/0/08", valid, instr, mem_addr);
        end
        pulse_start();
        checks++;
        if (state !== 2'b01 || valid !== 1'b0 || mem_addr !== 8'h00) begin
            failures++; $display("FAIL halt_restart got=%b/%b/%h exp=01/0/00", state, valid, mem_addr);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || instr_pc !== 8'h00) begin
            failures++; $display("FAIL halt_refetch got=%b/%h exp=1/00", valid, instr_pc);
        end
    endtask

    task automatic test_redirect_halt();
        do_reset();
        pulse_start();
        repeat (2) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        pulse_start();
        checks++;
        if (valid !== 1'b0 || state !== 2'b01 || mem_addr !== 8'h00) begin
            failures++; $display("FAIL restart_flush got=%b/%b/%h exp=0/01/00", valid, state, mem_addr);
        end
        tick();
        redir = 1'b1; halt = 1'b1; target = 8'h20;
        tick();
        redir = 1'b0; halt = 1'b0;
        checks++;
        if (state !== 2'b10 || mem_addr !== 8'h20 || valid !== 1'b0) begin
            failures++; $display("FAIL redir_halt got=%b/%h/%b exp=10/20/0", state, mem_addr, valid);
        end
        tick();
        checks++;
        if (mem_addr !== 8'h20 || valid !== 1'b0) begin
            failures++; $display("FAIL halted_nopush got=%h/%b exp=20/0", mem_addr, valid);
        end
        redir = 1'b1; target = 8'h30;
        tick();
        redir = 1'b0;
        checks++;
        if (state !== 2'b10 || mem_addr !== 8'h30) begin
            failures++; $display("FAIL halted_redir got=%b/%h exp=10/30", state, mem_addr);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        ready = 1'b1;
        pulse_start();
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        checks += 2;
        if (valid !== 1'b0 || mem_addr !== 8'h00) begin
            failures++; $display("FAIL async_rst got=%b/%h exp=0/00", valid, mem_addr);
        end
        if (state !== 2'b00 || instr !== 32'h0) begin
            failures++; $display("FAIL async_rst_state got=%b/%h exp=00/0", state, instr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; halt = 1'b0; redir = 1'b0; target = 8'h00; ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_bytes[i] = byte_of(8'(i));
        end
        test_reset();
        test_idle_ignores();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_redirect_halt();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Instruction-fetch sequencer for the CPU's byte-addressed program memory (8-bit address, 32-bit combinational little-endian read of bytes addr..addr+3).
- Owns the program counter, drives the memory address, and captures each fetched word with its PC into a small prefetch FIFO.
- Hands instructions to decode over a valid/ready handshake.
- Handles start, halt and branch-redirect (flush) sequencing.

Parameters:
- RESET_PC, 8'h00, PC value loaded at reset and on start_i.
- DEPTH, 2, prefetch FIFO entries; legal values 2 or 4.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  pulse: IDLE->RUN, PC<=RESET_PC.
- halt_i  input  1  level/pulse: RUN->HALTED.
- redirect_valid_i  input  1  branch/jump redirect request.
- redirect_target_i  input  8  new byte-address PC.
- mem_addr_o  output  8  address to program memory; equals PC register.
- mem_instr_i  input  32  instruction word returned combinationally for mem_addr_o.
- instr_o  output  32  FIFO head instruction.
- instr_pc_o  output  8  PC of FIFO head.
- instr_valid_o  output  1  FIFO non-empty.
- instr_ready_i  input  1  decode accepts head.
- state_o  output  2  00 IDLE, 01 RUN, 10 HALTED.

Behaviour:
- Reset (async, rst_ni=0): PC=RESET_PC, state=IDLE, FIFO empty. Outputs: mem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0, state_o=00. Reset mid-fetch discards all buffered entries immediately.
- Head outputs: instr_o and instr_pc_o read 0 whenever the FIFO is empty.
- Pop: when instr_valid_o && instr_ready_i, the head is removed at the clock edge.
- Push: occurs in RUN only, when the FIFO is not full or a pop happens the same cycle. The push writes {mem_instr_i, PC} into the FIFO tail and sets PC<=PC+4 (mod 256, wraps 8'hFC->8'h00).
- Fetch-to-valid latency: 1 cycle. A word fetched in cycle N appears at instr_o in cycle N+1 if the FIFO was empty.
- Full FIFO with no pop: no push, PC holds, mem_addr_o stable.
- Throughput: sustained 1 instruction/cycle when instr_ready_i=1.
- State transitions:
  - IDLE: start_i -> RUN, PC<=RESET_PC. Other inputs are ignored, including redirect.
  - RUN: halt_i -> HALTED; no push in the cycle halt_i is asserted.
  - HALTED: no pushes; FIFO continues draining via pops; start_i -> RUN with PC<=RESET_PC and FIFO flushed.
  - HALTED: redirect loads PC and flushes, but the state stays HALTED.
- Redirect (RUN or HALTED): at the edge, PC<=redirect_target_i, all FIFO entries are flushed, and no push occurs that cycle.
  - A head accepted the same cycle (valid&&ready) counts as consumed.
  - First post-redirect instruction is visible 2 cycles after the redirect cycle (flush cycle, then fetch cycle).
  - Target is used unaligned as-is; memory wrap of addr+1..+3 is the memory's concern.
- Simultaneous events in RUN: redirect_valid_i and halt_i together -> redirect applied AND state->HALTED. start_i in RUN is ignored.
- FIFO pointers wrap modulo DEPTH; an explicit count distinguishes full from empty.

Test Plan:
- Reset, start_i pulse, instr_ready_i=1, memory holding words W0..W3 at 0,4,8,12 -> instr_valid_o rises 1 cycle after start edge. Sequence instr_pc_o=0,4,8,12 with matching words on consecutive cycles.
- Backpressure: instr_ready_i=0 for 5 cycles after start -> exactly DEPTH=2 entries (PC 0,4), mem_addr_o held at 8. Release ready -> outputs 0,4,8 in order with no loss or duplication.
- Redirect to 8'h40 while FIFO holds PC 0x10,0x14 -> both flushed, instr_valid_o=0 next cycle. Next delivered instr_pc_o=0x40, then 0x44.
- Wrap: redirect to 8'hF8 -> delivered PCs F8, FC, 00, 04.
- Halt with 2 buffered entries -> state_o=10, no further mem_addr_o change, both entries still drain. start_i then restarts at RESET_PC with an empty FIFO.
- Assert rst_ni=0 mid-stream between clock edges -> instr_valid_o=0 and mem_addr_o=RESET_PC immediately (asynchronously), state_o=00.
